gmii_tx_scheduler: RTL and testbench
====================================

# gmii_tx_scheduler

Two-requester transmit scheduler that shares the GMII transmit path (TXD/TX_EN/TX_ER) in front of the PCS transmit ordered-set block. It grants the path round-robin and prefixes every frame with preamble and SFD. It enforces frame-length and inter-packet-gap rules, and aborts frames with TX_ER on requester underrun or over-length. Outputs drive the PCS transmit inputs directly on GTX_CLK.

## Interface
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (1..255)
- IPG_CYCLES, 12, minimum TX_EN-low cycles between frames (1..255)
- MAX_BYTES, 1518, maximum payload bytes per frame after SFD (1..65535)
- GTX_CLK  in  1  transmit clock, all logic on rising edge
- mr_main_reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a byte / frame pending
- req0_data  in  8  requester 0 byte
- req0_last  in  1  req0_data is final byte of frame
- req0_ready  out  1  byte on req0_data accepted this edge (combinational: state==DATA && grant[0])
- req1_valid, req1_data, req1_last, req1_ready: same as requester 0
- TXD  out  8  GMII transmit data, registered
- TX_EN  out  1  GMII transmit enable, registered
- TX_ER  out  1  GMII transmit error, registered
- grant  out  2  one-hot owner of current frame, registered; 00 when none
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, IPG. Reset state IDLE.
- Reset values: TXD=0x00, TX_EN=0, TX_ER=0, grant=00, busy=0, req*_ready=0, counters 0, round-robin pointer last=1 (requester 0 wins first tie).
- IDLE: if any reqN_valid, grant the valid one; if both, grant the one != last; last<=granted; go PREAMBLE, TXD<=0x55, TX_EN<=1, cnt<=1.
- PREAMBLE: emit 0x55 per cycle until PREAMBLE_LEN bytes total, then TXD<=0xD5, state SFD→DATA (SFD is exactly one cycle).
- Requester holds valid/first byte untouched through PREAMBLE/SFD; ready=0 there.
- DATA: ready=1 to granted requester only. Each edge:
  - valid=1: TXD<=data, TX_EN<=1, TX_ER<=0, bytecnt++; if last: state IPG.
  - valid=1, not last, bytecnt reaches MAX_BYTES on this byte: next edge forces abort (ready=0 that cycle).
  - valid=0 (underrun) or abort: TXD<=0x00, TX_EN<=1, TX_ER<=1 for one cycle, state IPG; remaining requester bytes are not consumed (requester must drop its frame).
- IPG: TX_EN<=0, TX_ER<=0, TXD<=0x00, grant<=00; count IPG_CYCLES edges, then IDLE.
- Non-granted requester never sees ready=1; its valid is ignored until next IDLE arbitration.
- Round-robin: pointer updates only on grant; single requester may be granted back-to-back.

## Timing
- Request to first TX_EN: edge sampling valid in IDLE sets TX_EN=1 (one cycle latency).
- TX_EN high for PREAMBLE_LEN + 1 + N cycles for an N-byte good frame (N ≤ MAX_BYTES).
- Byte accepted at edge k appears on TXD after edge k (1-cycle latency), back-to-back, no bubbles.
- Gap: TX_EN low exactly IPG_CYCLES cycles minimum; exactly IPG_CYCLES when next request already valid.
- Aborted frame: exactly one TX_EN=1/TX_ER=1 cycle following the last good byte, then IPG.
- TX_ER never asserted with TX_EN=0.
- Async reset mid-frame: outputs go to reset values immediately, no TX_ER, frame truncated; after release, IDLE, pointer last=1.
- Counters: byte counter 16 bits, preamble/IPG counter 8 bits; no wrap within legal parameter ranges.

## Test plan
- Reset: hold mr_main_reset=0 with both valids high -> TXD=00, TX_EN=0, TX_ER=0, grant=00, ready=0 throughout.
- Single frame: req0 bytes 01 03 9A B5 42 02 42 9A B5 00 (last on 00) -> 7×55, D5, those 10 bytes; TX_EN high 18 cycles; then 12 low cycles.
- Contention: both valid in IDLE -> req0 frame, exactly 12 idle cycles, req1 frame, then req0 again; grant 01,00,10,00,01.
- Underrun: req1 sends 01 03 9A then drops valid -> D5,01,03,9A, one cycle TXD=00/TX_EN=1/TX_ER=1, then TX_EN=0 for 12 cycles.
- Over-length: MAX_BYTES=64, req0 streams 70 bytes without last -> 64 bytes on TXD, ready=0 on 65th cycle, one TX_ER cycle, IPG.
- Reset mid-frame: assert mr_main_reset=0 during byte 5 -> TX_EN=0 asynchronously; after release, first tie grants req0.

Source files
------------

// File: rtl/gmii_tx_scheduler.sv
// rtl/gmii_tx_scheduler.sv - two-requester GMII transmit scheduler with preamble, IPG and abort
module gmii_tx_scheduler #(
   parameter int PREAMBLE_LEN = 7,
   parameter int IPG_CYCLES   = 12,
   parameter int MAX_BYTES    = 1518
) (
   input  logic       GTX_CLK,
   input  logic       mr_main_reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] TXD,
   output logic       TX_EN,
   output logic       TX_ER,
   output logic [1:0] grant,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_IPG
   } state_t;

   localparam logic [7:0]  PRE_LEN_B  = 8'(PREAMBLE_LEN);
   localparam logic [7:0]  IPG_LAST_B = 8'(IPG_CYCLES - 1);
   localparam logic [15:0] MAX_B      = 16'(MAX_BYTES);

   state_t      state_q, state_d;
   logic [7:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_q, last_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] bytecnt_q, bytecnt_d;
   logic        abort_q, abort_d;

   logic        pick;
   logic        sel_valid;
   logic [7:0]  sel_data;
   logic        sel_last;
   logic [7:0]  cnt_inc;
   logic [15:0] bytecnt_inc;

   assign sel_valid   = grant_q[1] ? req1_valid : req0_valid;
   assign sel_data    = grant_q[1] ? req1_data  : req0_data;
   assign sel_last    = grant_q[1] ? req1_last  : req0_last;
   assign cnt_inc     = cnt_q + 8'd1;
   assign bytecnt_inc = bytecnt_q + 16'd1;

   // A pending abort withholds ready so the offending byte is not consumed
   assign req0_ready = (state_q == ST_DATA) && grant_q[0] && !abort_q;
   assign req1_ready = (state_q == ST_DATA) && grant_q[1] && !abort_q;
   assign TXD        = txd_q;
   assign TX_EN      = tx_en_q;
   assign TX_ER      = tx_er_q;
   assign grant      = grant_q;
   assign busy       = (state_q != ST_IDLE);

   // Next-state and next-output computation for the frame sequencer
   always_comb begin
      state_d   = state_q;
      txd_d     = txd_q;
      tx_en_d   = tx_en_q;
      tx_er_d   = tx_er_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      bytecnt_d = bytecnt_q;
      abort_d   = abort_q;
      pick      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            txd_d   = 8'h00;
            tx_en_d = 1'b0;
            tx_er_d = 1'b0;
            grant_d = 2'b00;
            if (req0_valid || req1_valid) begin
               // On a tie, the requester not served last wins
               pick      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
               grant_d   = pick ? 2'b10 : 2'b01;
               last_d    = pick;
               txd_d     = 8'h55;
               tx_en_d   = 1'b1;
               cnt_d     = 8'd1;
               bytecnt_d = 16'd0;
               abort_d   = 1'b0;
               state_d   = (PRE_LEN_B == 8'd1) ? ST_SFD : ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            // SFD state covers the final preamble byte so D5 leads straight into data
            txd_d = 8'h55;
            cnt_d = cnt_inc;
            if (cnt_inc == PRE_LEN_B) begin
               state_d = ST_SFD;
            end
         end
         ST_SFD: begin
            txd_d   = 8'hD5;
            cnt_d   = 8'd0;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (abort_q || !sel_valid) begin
               txd_d   = 8'h00;
               tx_en_d = 1'b1;
               tx_er_d = 1'b1;
               abort_d = 1'b0;
               cnt_d   = 8'd0;
               state_d = ST_IPG;
            end else begin
               txd_d     = sel_data;
               tx_en_d   = 1'b1;
               tx_er_d   = 1'b0;
               bytecnt_d = bytecnt_inc;
               if (sel_last) begin
                  cnt_d   = 8'd0;
                  state_d = ST_IPG;
               end else if (bytecnt_inc == MAX_B) begin
                  abort_d = 1'b1;
               end
            end
         end
         ST_IPG: begin
            txd_d   = 8'h00;
            tx_en_d = 1'b0;
            tx_er_d = 1'b0;
            grant_d = 2'b00;
            if (cnt_q == IPG_LAST_B) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered GMII outputs; async reset truncates any frame silently
   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state_q   <= ST_IDLE;
         txd_q     <= 8'h00;
         tx_en_q   <= 1'b0;
         tx_er_q   <= 1'b0;
         grant_q   <= 2'b00;
         last_q    <= 1'b1;
         cnt_q     <= 8'd0;
         bytecnt_q <= 16'd0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         txd_q     <= txd_d;
         tx_en_q   <= tx_en_d;
         tx_er_q   <= tx_er_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         bytecnt_q <= bytecnt_d;
         abort_q   <= abort_d;
      end
   end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// tb/tb_gmii_tx_scheduler.sv - directed vector bench for gmii_tx_scheduler
module tb_gmii_tx_scheduler;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic [7:0] txd;
      logic       en;
      logic       er;
      logic       r0;
      logic       r1;
      logic [1:0] g;
      logic       busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic [7:0] TXD;
   logic       TX_EN, TX_ER, busy;
   logic [1:0] grant;

   always #5 clk = ~clk;

   gmii_tx_scheduler #(
      .PREAMBLE_LEN(7),
      .IPG_CYCLES(12),
      .MAX_BYTES(64)
   ) dut (
      .GTX_CLK(clk),
      .mr_main_reset(rst_n),
      .req0_valid(req0_valid),
      .req0_data(req0_data),
      .req0_last(req0_last),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_data(req1_data),
      .req1_last(req1_last),
      .req1_ready(req1_ready),
      .TXD(TXD),
      .TX_EN(TX_EN),
      .TX_ER(TX_ER),
      .grant(grant),
      .busy(busy)
   );

   int total = 0;
   int passed = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   int pos0, pos1, acc0_total;

   logic       lg_en[$];
   logic       lg_er[$];
   logic [7:0] lg_txd[$];
   logic [1:0] lg_g[$];
   int rs[$];
   int rl[$];
   logic [1:0] gq[$];

   vec_t tv[$];
   bq_t sf, pa, pb, pc, pl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic load(input int r, input bq_t f, input bit with_last);
      for (int i = 0; i < f.size(); i++) begin
         if (r == 0) q0.push_back({with_last && (i == f.size() - 1), f[i]});
         else        q1.push_back({with_last && (i == f.size() - 1), f[i]});
      end
   endtask

   task automatic drive();
      req0_valid = (pos0 < q0.size());
      {req0_last, req0_data} = req0_valid ? q0[pos0] : 9'h000;
      req1_valid = (pos1 < q1.size());
      {req1_last, req1_data} = req1_valid ? q1[pos1] : 9'h000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q0.delete(); q1.delete();
      pos0 = 0; pos1 = 0;
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run(input int ncyc);
      logic a0, a1;
      lg_en.delete(); lg_er.delete(); lg_txd.delete(); lg_g.delete();
      drive();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         a0 = req0_ready;
         a1 = req1_ready;
         chk("ready_owner", 32'({req1_ready, req0_ready} & ~grant), 32'd0);
         @(posedge clk);
         #1;
         if (a0) begin pos0++; acc0_total++; end
         if (a1) pos1++;
         chk("er_without_en", 32'(TX_ER & ~TX_EN), 32'd0);
         lg_en.push_back(TX_EN);
         lg_er.push_back(TX_ER);
         lg_txd.push_back(TXD);
         lg_g.push_back(grant);
         if (TX_ER) begin
            if (grant[0]) begin q0.delete(); pos0 = 0; end
            if (grant[1]) begin q1.delete(); pos1 = 0; end
         end
         drive();
      end
   endtask

   task automatic find_runs();
      rs.delete(); rl.delete(); gq.delete();
      for (int i = 0; i < lg_en.size(); i++) begin
         if (lg_en[i] && (i == 0 || !lg_en[i-1])) begin
            rs.push_back(i);
            rl.push_back(0);
         end
         if (lg_en[i]) rl[rl.size()-1]++;
         if (gq.size() == 0 || gq[gq.size()-1] != lg_g[i]) gq.push_back(lg_g[i]);
      end
   endtask

   task automatic chk_frame(input int k, input bq_t p);
      int b;
      logic anyer;
      chk($sformatf("frame%0d_present", k), 32'(rs.size() > k), 32'd1);
      if (rs.size() > k) begin
         b = rs[k];
         chk($sformatf("frame%0d_len", k), 32'(rl[k]), 32'(8 + p.size()));
         for (int i = 0; i < 7; i++) chk($sformatf("frame%0d_pre%0d", k, i), 32'(lg_txd[b+i]), 32'h55);
         chk($sformatf("frame%0d_sfd", k), 32'(lg_txd[b+7]), 32'hD5);
         for (int i = 0; i < p.size(); i++)
            chk($sformatf("frame%0d_byte%0d", k, i), 32'(lg_txd[b+8+i]), 32'(p[i]));
         anyer = 1'b0;
         for (int i = 0; i < rl[k]; i++) anyer = anyer | lg_er[b+i];
         chk($sformatf("frame%0d_no_er", k), 32'(anyer), 32'd0);
      end
   endtask

   initial begin
      sf = '{8'h01, 8'h03, 8'h9A, 8'hB5, 8'h42, 8'h02, 8'h42, 8'h9A, 8'hB5, 8'h00};
      pa = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      pb = '{8'hB0, 8'hB1, 8'hB2};
      pc = '{8'hC0, 8'hC1};

      // Underrun on req1 after 01 03 9A; req0 asks late and must wait for IPG
      for (int i = 0; i < 25; i++) begin
         vec_t v;
         v.v1   = (i <= 10);
         v.d1   = (i == 9) ? 8'h03 : (i == 10) ? 8'h9A : 8'h01;
         v.v0   = (i >= 8);
         v.d0   = 8'h77;
         v.txd  = (i <= 6) ? 8'h55 : (i == 7) ? 8'hD5 : (i == 8) ? 8'h01 :
                  (i == 9) ? 8'h03 : (i == 10) ? 8'h9A : (i == 24) ? 8'h55 : 8'h00;
         v.en   = (i <= 11) || (i == 24);
         v.er   = (i == 11);
         v.r0   = 1'b0;
         v.r1   = (i >= 7) && (i <= 10);
         v.g    = (i <= 11) ? 2'b10 : (i == 24) ? 2'b01 : 2'b00;
         v.busy = (i != 23);
         tv.push_back(v);
      end

      // Reset held with both requesters asking
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b0;
      pos0 = 0; pos1 = 0; acc0_total = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("reset_outputs", 32'({TXD, TX_EN, TX_ER, grant, req0_ready, req1_ready, busy}), 32'd0);
      end
      do_reset();

      // Table: underrun and back-to-back request
      for (int i = 0; i < tv.size(); i++) begin
         req0_valid = tv[i].v0; req0_data = tv[i].d0; req0_last = 1'b0;
         req1_valid = tv[i].v1; req1_data = tv[i].d1; req1_last = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), 32'({TXD, TX_EN, TX_ER, req0_ready, req1_ready, grant, busy}),
             32'({tv[i].txd, tv[i].en, tv[i].er, tv[i].r0, tv[i].r1, tv[i].g, tv[i].busy}));
      end

      // Single 10-byte frame on req0
      do_reset();
      load(0, sf, 1'b1);
      run(45);
      find_runs();
      chk("single_run_count", 32'(rs.size()), 32'd1);
      if (rs.size() > 0) begin
         chk("single_first_en_latency", 32'(rs[0]), 32'd0);
         chk("single_ipg_low", 32'(lg_en.size() - (rs[0] + rl[0]) >= 12), 32'd1);
      end
      chk_frame(0, sf);

      // Contention: A (req0), B (req1), then C (req0) already pending
      do_reset();
      load(0, pa, 1'b1);
      load(0, pc, 1'b1);
      load(1, pb, 1'b1);
      run(80);
      find_runs();
      chk("cont_run_count", 32'(rs.size()), 32'd3);
      chk_frame(0, pa);
      chk_frame(1, pb);
      chk_frame(2, pc);
      if (rs.size() >= 3) begin
         chk("cont_gap0", 32'(rs[1] - (rs[0] + rl[0])), 32'd12);
         chk("cont_gap1", 32'(rs[2] - (rs[1] + rl[1])), 32'd12);
      end
      chk("cont_grant_seq_len", 32'(gq.size() >= 5), 32'd1);
      if (gq.size() >= 5)
         chk("cont_grant_seq", 32'({gq[0], gq[1], gq[2], gq[3], gq[4]}), 32'b01_00_10_00_01);

      // Over-length: 70 bytes without last, limit 64
      do_reset();
      acc0_total = 0;
      pl.delete();
      for (int i = 0; i < 70; i++) pl.push_back(8'(i + 3));
      load(0, pl, 1'b0);
      run(100);
      find_runs();
      chk("ovl_run_count", 32'(rs.size()), 32'd1);
      chk("ovl_accepted", 32'(acc0_total), 32'd64);
      if (rs.size() > 0) begin
         chk("ovl_len", 32'(rl[0]), 32'd73);
         for (int i = 0; i < 64; i++)
            chk($sformatf("ovl_byte%0d", i), 32'(lg_txd[rs[0]+8+i]), 32'(i + 3));
         chk("ovl_er_before", 32'(lg_er[rs[0]+71]), 32'd0);
         chk("ovl_err_cycle", 32'({lg_txd[rs[0]+72], lg_er[rs[0]+72]}), 32'h001);
         chk("ovl_ipg_low", 32'(lg_en.size() - (rs[0] + rl[0]) >= 12), 32'd1);
      end

      // Async reset during byte 5, then first tie goes to req0
      do_reset();
      load(0, sf, 1'b1);
      run(13);
      chk("midreset_byte5", 32'({lg_en[12], lg_txd[12]}), 32'h142);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_async", 32'({TXD, TX_EN, TX_ER, grant, req0_ready, req1_ready, busy}), 32'd0);
      @(posedge clk);
      #1;
      q0.delete(); q1.delete(); pos0 = 0; pos1 = 0;
      load(0, pc, 1'b1);
      load(1, pb, 1'b1);
      drive();
      rst_n = 1'b1;
      run(3);
      chk("midreset_first_tie", 32'(lg_g[0]), 32'b01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
